// File: rtl/freq_meter_gate.sv
// -----------------------------------------------------------------------------
// freq_meter_gate
//   Gated-window frequency meter. Counts rising edges of an asynchronous
//   signal over a window of exactly GATE_CYCLES clk_i periods and reports the
//   count. Runs single-shot (start_i) or continuously (cont_i re-arms in DONE).
//
// Ports
//   clk_i    in   1      system clock; the only clock
//   rst_i    in   1      synchronous active-high reset
//   sig_i    in   1      asynchronous signal under measurement
//   start_i  in   1      request a measurement; sampled only in IDLE
//   cont_i   in   1      1 = re-arm automatically after each result
//   busy_o   out  1      high while in GATE or DONE
//   valid_o  out  1      one-cycle pulse when freq_o/ovf_o are updated
//   freq_o   out  CNT_W  rising-edge count of the last completed window
//   ovf_o    out  1      last window saturated the edge counter
// -----------------------------------------------------------------------------
module freq_meter_gate #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             start_i,
  input  logic             cont_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] freq_o,
  output logic             ovf_o
);

  localparam int unsigned       GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, p_q;
  logic             rise_s;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // Two-flop synchronizer followed by the previous-value flop for edge detect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      p_q  <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      p_q  <= s2_q;
    end
  end

  assign rise_s = s2_q & ~p_q;

  // Next-state and datapath update for the measurement FSM.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_GATE: begin
        gate_cnt_d = gate_cnt_q + GW'(1);
        // A rise on the final GATE cycle still lands in edge_cnt before DONE.
        if (rise_s) begin
          if (edge_cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end else begin
          edge_cnt_d = edge_cnt_q;
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_GATE;
        end
      end

      ST_DONE: begin
        // Publish result; rises seen in this cycle are deliberately dropped.
        freq_d  = edge_cnt_q;
        ovf_d   = sat_q;
        valid_d = 1'b1;
        if (cont_i) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign freq_o  = freq_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_freq_meter_gate.sv
// Directed bench for freq_meter_gate: a 12-bit instance for the main
// scenarios and a 6-bit instance for counter saturation.
module tb_freq_meter_gate;

  localparam int GC = 1000;

  logic        clk = 1'b0;
  logic        rst, sig, start, start2, cont;
  logic        busy, valid, ovf;
  logic [11:0] freq;
  logic        busy2, valid2, ovf2;
  logic [5:0]  freq2;

  int n_checks = 0;
  int n_fail   = 0;
  int sig_period = 0;
  int sig_ph = 0;

  freq_meter_gate #(.GATE_CYCLES(GC), .CNT_W(12)) dut (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .start_i(start), .cont_i(cont),
    .busy_o(busy), .valid_o(valid), .freq_o(freq), .ovf_o(ovf)
  );

  freq_meter_gate #(.GATE_CYCLES(GC), .CNT_W(6)) dut2 (
    .clk_i(clk), .rst_i(rst), .sig_i(sig), .start_i(start2), .cont_i(cont),
    .busy_o(busy2), .valid_o(valid2), .freq_o(freq2), .ovf_o(ovf2)
  );

  always #5 clk = ~clk;

  // Square-wave source: sig_period clk cycles per period, 50% duty; 0 = held low.
  initial begin
    sig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sig_period == 0) begin
        sig    = 1'b0;
        sig_ph = 0;
      end else begin
        if (sig_ph >= sig_period) sig_ph = 0;
        sig    = (sig_ph < sig_period / 2);
        sig_ph = sig_ph + 1;
      end
    end
  end

  // Returns just after the edge that accepts start (edge E0).
  task automatic pulse_start(input bit sel2);
    @(posedge clk); #1;
    if (sel2) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts cycles until valid is seen; lat = 0 when the budget expires.
  task automatic wait_valid(input bit sel2, input int budget, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (sel2 ? busy2 : busy) busy_n++;
      if (sel2 ? valid2 : valid) begin
        lat = n;
        break;
      end
    end
  endtask

  // Counts valid pulses of the main instance over a number of cycles.
  task automatic count_valids(input int cycles, output int vcnt);
    vcnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; cont = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (freq !== 12'd0)  begin n_fail++; $display("FAIL reset_freq: got %0d expected 0", freq); end
    n_checks++; if (ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (freq2 !== 6'd0)  begin n_fail++; $display("FAIL reset_freq2: got %0d expected 0", freq2); end
    n_checks++; if (busy2 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    @(posedge clk); #1;
    rst = 1'b0;
    sig_period = 10;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_single();
    int lat, bn;
    sig_period = 10;
    pulse_start(1'b0);
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1002)   begin n_fail++; $display("FAIL single_latency: got %0d expected 1002", lat); end
    n_checks++; if (bn !== 1001)    begin n_fail++; $display("FAIL single_busy_len: got %0d expected 1001", bn); end
    n_checks++; if (freq !== 12'd100) begin n_fail++; $display("FAIL single_freq: got %0d expected 100", freq); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL single_ovf: got %b expected 0", ovf); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", valid); end
    n_checks++; if (freq !== 12'd100) begin n_fail++; $display("FAIL single_freq_hold: got %0d expected 100", freq); end
  endtask

  task automatic test_zero();
    int lat, bn, vc;
    sig_period = 0;
    repeat (10) @(posedge clk);
    pulse_start(1'b0);
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1002)   begin n_fail++; $display("FAIL zero_latency: got %0d expected 1002", lat); end
    n_checks++; if (freq !== 12'd0) begin n_fail++; $display("FAIL zero_freq: got %0d expected 0", freq); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL zero_ovf: got %b expected 0", ovf); end
    count_valids(1100, vc);
    n_checks++; if (vc !== 0)       begin n_fail++; $display("FAIL zero_extra_valid: got %0d expected 0", vc); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL zero_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_continuous();
    int lat, bn, vc;
    sig_period = 20;
    repeat (10) @(posedge clk);
    cont = 1'b1;
    pulse_start(1'b0);
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1002)   begin n_fail++; $display("FAIL cont_first_latency: got %0d expected 1002", lat); end
    n_checks++; if (freq !== 12'd50) begin n_fail++; $display("FAIL cont_freq_p20_a: got %0d expected 50", freq); end
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1001)   begin n_fail++; $display("FAIL cont_spacing_a: got %0d expected 1001", lat); end
    n_checks++; if (freq !== 12'd50) begin n_fail++; $display("FAIL cont_freq_p20_b: got %0d expected 50", freq); end
    sig_period = 8;
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1001)   begin n_fail++; $display("FAIL cont_spacing_b: got %0d expected 1001", lat); end
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1001)   begin n_fail++; $display("FAIL cont_spacing_c: got %0d expected 1001", lat); end
    n_checks++; if (freq !== 12'd125) begin n_fail++; $display("FAIL cont_freq_p8_a: got %0d expected 125", freq); end
    cont = 1'b0;
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1001)   begin n_fail++; $display("FAIL cont_spacing_d: got %0d expected 1001", lat); end
    n_checks++; if (freq !== 12'd125) begin n_fail++; $display("FAIL cont_freq_p8_b: got %0d expected 125", freq); end
    count_valids(1100, vc);
    n_checks++; if (vc !== 0)       begin n_fail++; $display("FAIL cont_stop_valid: got %0d expected 0", vc); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL cont_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_saturate();
    int lat, bn;
    sig_period = 4;
    repeat (10) @(posedge clk);
    pulse_start(1'b1);
    wait_valid(1'b1, 1100, lat, bn);
    n_checks++; if (lat !== 1002)   begin n_fail++; $display("FAIL sat_latency: got %0d expected 1002", lat); end
    n_checks++; if (freq2 !== 6'd63) begin n_fail++; $display("FAIL sat_freq: got %0d expected 63", freq2); end
    n_checks++; if (ovf2 !== 1'b1)  begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", ovf2); end
    sig_period = 40;
    repeat (50) @(posedge clk);
    pulse_start(1'b1);
    wait_valid(1'b1, 1100, lat, bn);
    n_checks++; if (freq2 !== 6'd25) begin n_fail++; $display("FAIL sat_recover_freq: got %0d expected 25", freq2); end
    n_checks++; if (ovf2 !== 1'b0)  begin n_fail++; $display("FAIL sat_recover_ovf: got %b expected 0", ovf2); end
  endtask

  task automatic test_abort();
    int lat, bn, vc;
    sig_period = 10;
    repeat (10) @(posedge clk);
    pulse_start(1'b0);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (freq !== 12'd0) begin n_fail++; $display("FAIL abort_freq: got %0d expected 0", freq); end
    n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL abort_ovf: got %b expected 0", ovf); end
    count_valids(1200, vc);
    n_checks++; if (vc !== 0)       begin n_fail++; $display("FAIL abort_no_valid: got %0d expected 0", vc); end
    pulse_start(1'b0);
    wait_valid(1'b0, 1100, lat, bn);
    n_checks++; if (lat !== 1002)   begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected 1002", lat); end
    n_checks++; if (freq !== 12'd100) begin n_fail++; $display("FAIL abort_restart_freq: got %0d expected 100", freq); end
  endtask

  task automatic test_restart_ignored();
    int lat, vc;
    lat = 0;
    vc  = 0;
    sig_period = 10;
    repeat (10) @(posedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    // start stays high through GATE; dropped during the DONE cycle.
    for (int n = 1; n <= 2300; n++) begin
      @(negedge clk);
      if (n == 1001) start = 1'b0;
      if (valid) begin
        vc++;
        if (lat == 0) lat = n;
      end
    end
    n_checks++; if (vc !== 1)       begin n_fail++; $display("FAIL restart_valid_count: got %0d expected 1", vc); end
    n_checks++; if (lat !== 1002)   begin n_fail++; $display("FAIL restart_latency: got %0d expected 1002", lat); end
    n_checks++; if (freq !== 12'd100) begin n_fail++; $display("FAIL restart_freq: got %0d expected 100", freq); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL restart_busy: got %b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; cont = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_continuous();
    test_saturate();
    test_abort();
    test_restart_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
